schedule_ctrl: RTL and testbench
================================

SCHEDULE_CTRL -- requirements
Module: schedule_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000: adjust-state inactivity limit, in clk cycles.
REQ-002 Parameter RING_CYC, default 500: maximum alarm ring duration, in clk cycles.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset: 0 resets the block immediately, independent of clk.
REQ-005 btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  debounced button levels: centre, left, right, up, down.
REQ-006 alarm_en  in  1  alarm arm switch level.
REQ-007 H1 [1:0], H2 [3:0], M1 [2:0], M2 [3:0]  in  current time digits.
REQ-008 AH1 [1:0], AH2 [3:0], AM1 [2:0], AM2 [3:0]  in  alarm time digits.
REQ-009 adjust  out  1  time-counter adjust mode.
REQ-010 ENTH, ENTM  out  1 each  time-counter hour/minute step enables.
REQ-011 updown  out  1  step direction: 0 up, 1 down; shared by time and alarm counters.
REQ-012 a_adjust, A_ENTH, A_ENTM  out  1 each  alarm-counter adjust mode and hour/minute step enables.
REQ-013 led [4:0]  out  one-hot state indicator, in order {A_MIN, A_HR, T_MIN, T_HR, CLOCK}.
REQ-014 ring  out  1  alarm sounding.

Function
REQ-015 Button edge detection: each btn_* is registered; an event is a registered 0->1 transition, one cycle per press, one cycle of latency.
REQ-016 FSM states: CLOCK, T_HR, T_MIN, A_HR, A_MIN.
REQ-017 CLOCK transitions: btn_c event -> T_HR; all other events ignored.
REQ-018 Adjust-state transitions: btn_c event -> CLOCK from any adjust state.
REQ-019 btn_r event cycles forward T_HR->T_MIN->A_HR->A_MIN->T_HR; btn_l event cycles in reverse.
REQ-020 Simultaneous events in the same cycle: priority btn_c > (btn_l/btn_r) > (btn_u/btn_d); only the highest-priority event acts.
REQ-021 btn_l and btn_r events together are both ignored; btn_u and btn_d events together are both ignored.
REQ-022 adjust=1 exactly in T_HR and T_MIN; a_adjust=1 exactly in A_HR and A_MIN.
REQ-023 Steps: a btn_u or btn_d event in an adjust state asserts the enable for that state's field (ENTH, ENTM, A_ENTH or A_ENTM) for exactly one cycle, in the cycle after the event.
REQ-024 updown is 1 during a btn_d step and 0 during a btn_u step; updown is 0 whenever no step enable is asserted.
REQ-025 Enables are otherwise 0; at most one enable is high in any cycle.
REQ-026 Timeout: a counter clears on any button event and on entry to an adjust state.
REQ-027 Timeout: in an adjust state with no event for TIMEOUT consecutive cycles, the FSM returns to CLOCK; the counter is held at 0 in CLOCK.
REQ-028 Match: match = (H1,H2,M1,M2) == (AH1,AH2,AM1,AM2).
REQ-029 Ring set: ring rises one cycle after match goes 0->1 (registered previous match) while state==CLOCK and alarm_en=1; a match that is already stable does not re-trigger.
REQ-030 Ring clear: ring clears on any button event, on alarm_en=0, or after RING_CYC cycles high, whichever comes first.
REQ-031 A button event that clears ring is consumed: no transition and no step for that event.
REQ-032 Entering an adjust state is impossible while ring=1, because of REQ-031.

Reset
REQ-033 While rst=0: state=CLOCK, led=5'b00001, all enables, adjust, a_adjust, updown and ring are 0, and all counters and edge registers are 0.
REQ-034 Reset mid-operation (in an adjust state or while ringing) takes effect asynchronously, with no extra enable pulse.
REQ-035 After rst deasserts, a button already held high produces no event until it is released and pressed again; the edge registers reset to 0 and only 0->1 transitions count.

Verification (TIMEOUT=16, RING_CYC=8)
REQ-036 Press btn_c, btn_u x3 -> T_HR; adjust=1; three single-cycle ENTH pulses with updown=0; led=00010.
REQ-037 From T_HR press btn_r x2, then btn_d -> A_HR; one A_ENTH pulse with updown=1; btn_l from T_HR -> A_MIN.
REQ-038 btn_u and btn_d in the same cycle in T_MIN -> no ENTM pulse; btn_c and btn_r in the same cycle -> CLOCK.
REQ-039 Idle 16 cycles in T_MIN -> CLOCK at cycle 16; an event at cycle 15 restarts the count.
REQ-040 alarm_en=1 and time changes 06:59 -> 07:00 with alarm 07:00 -> ring=1 next cycle, ring=0 after 8 cycles; a btn_u press at ring cycle 3 clears ring with no state change.
REQ-041 rst pulled low while in A_MIN with a step pending -> CLOCK immediately, all outputs 0, no pulse after release.

Source files
------------

// File: rtl/schedule_ctrl.sv
// schedule_ctrl: clock/alarm adjust FSM with button edge detection, adjust timeout and alarm ring control.
module schedule_ctrl #(
    parameter int TIMEOUT  = 1000,
    parameter int RING_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_en,
    input  logic [1:0] H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic [1:0] AH1,
    input  logic [3:0] AH2,
    input  logic [2:0] AM1,
    input  logic [3:0] AM2,
    output logic       adjust,
    output logic       ENTH,
    output logic       ENTM,
    output logic       updown,
    output logic       a_adjust,
    output logic       A_ENTH,
    output logic       A_ENTM,
    output logic [4:0] led,
    output logic       ring
);
    typedef enum logic [2:0] {CLOCK, T_HR, T_MIN, A_HR, A_MIN} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RING_CYC + 1);
    state_t state, ns;
    logic [4:0] b_q, b_qq, ev;
    logic armed, match, match_q, act, step, tmo;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    // event bits {c, l, r, u, d}; a ringing alarm swallows the event
    assign ev    = b_q & ~b_qq;
    assign match = {H1, H2, M1, M2} == {AH1, AH2, AM1, AM2};
    assign act   = |ev && !ring;
    assign tmo   = state != CLOCK && ~|ev && tcnt == TW'(TIMEOUT - 1);
    assign step  = act && state != CLOCK && !ev[4] && !ev[3] && !ev[2] && (ev[1] ^ ev[0]);
    always_comb begin
        ns = state;
        if (act && ev[4])
            ns = (state == CLOCK) ? T_HR : CLOCK;
        else if (act && state != CLOCK && (ev[3] ^ ev[2]))
            case (state)
                T_HR:    ns = ev[2] ? T_MIN : A_MIN;
                T_MIN:   ns = ev[2] ? A_HR  : T_HR;
                A_HR:    ns = ev[2] ? A_MIN : T_MIN;
                default: ns = ev[2] ? T_HR  : A_HR;
            endcase
        else if (tmo)
            ns = CLOCK;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLOCK;
            b_q      <= '0;
            b_qq     <= '0;
            armed    <= 1'b0;
            match_q  <= 1'b0;
            tcnt     <= '0;
            rcnt     <= '0;
            ring     <= 1'b0;
            adjust   <= 1'b0;
            a_adjust <= 1'b0;
            ENTH     <= 1'b0;
            ENTM     <= 1'b0;
            A_ENTH   <= 1'b0;
            A_ENTM   <= 1'b0;
            updown   <= 1'b0;
            led      <= 5'b00001;
        end else begin
            b_q      <= {btn_c, btn_l, btn_r, btn_u, btn_d};
            // first cycle after reset loads the current level, so a held button is not an edge
            b_qq     <= armed ? b_q : {btn_c, btn_l, btn_r, btn_u, btn_d};
            armed    <= 1'b1;
            match_q  <= match;
            state    <= ns;
            tcnt     <= (ns == CLOCK || |ev) ? '0 : tcnt + TW'(1);
            adjust   <= ns == T_HR || ns == T_MIN;
            a_adjust <= ns == A_HR || ns == A_MIN;
            led      <= 5'b00001 << ns;
            ENTH     <= step && state == T_HR;
            ENTM     <= step && state == T_MIN;
            A_ENTH   <= step && state == A_HR;
            A_ENTM   <= step && state == A_MIN;
            updown   <= step && ev[0];
            if (ring) begin
                ring <= !(|ev || !alarm_en || rcnt == RW'(RING_CYC - 1));
                rcnt <= rcnt + RW'(1);
            end else begin
                ring <= match && !match_q && state == CLOCK && alarm_en && ~|ev;
                rcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_schedule_ctrl.sv
// tb_schedule_ctrl: table-driven directed vectors plus hand-written timeout, ring and reset sequences.
module tb_schedule_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic btn_c = 0, btn_l = 0, btn_r = 0, btn_u = 0, btn_d = 0, alarm_en = 0;
    logic [1:0] H1 = 2'd1, AH1 = 2'd0;
    logic [3:0] H2 = 4'd2, AH2 = 4'd7;
    logic [2:0] M1 = 3'd3, AM1 = 3'd0;
    logic [3:0] M2 = 4'd4, AM2 = 4'd0;
    logic adjust, ENTH, ENTM, updown, a_adjust, A_ENTH, A_ENTM, ring;
    logic [4:0] led;
    logic [12:0] outs;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    schedule_ctrl #(.TIMEOUT(16), .RING_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .alarm_en(alarm_en),
        .H1(H1), .H2(H2), .M1(M1), .M2(M2),
        .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
        .adjust(adjust), .ENTH(ENTH), .ENTM(ENTM), .updown(updown),
        .a_adjust(a_adjust), .A_ENTH(A_ENTH), .A_ENTM(A_ENTM),
        .led(led), .ring(ring)
    );

    // {led, adjust, a_adjust, ENTH, ENTM, A_ENTH, A_ENTM, updown, ring}
    assign outs = {led, adjust, a_adjust, ENTH, ENTM, A_ENTH, A_ENTM, updown, ring};

    localparam logic [12:0] CLK_O = {5'b00001, 8'b0000_0000};
    localparam logic [12:0] TH    = {5'b00010, 8'b1000_0000};
    localparam logic [12:0] TM    = {5'b00100, 8'b1000_0000};
    localparam logic [12:0] AH    = {5'b01000, 8'b0100_0000};
    localparam logic [12:0] AM    = {5'b10000, 8'b0100_0000};
    localparam logic [12:0] E_TH = 13'h020, E_TM = 13'h010, E_AH = 13'h008, E_AM = 13'h004;
    localparam logic [12:0] UD = 13'h002, RG = 13'h001;
    localparam logic [4:0] C = 5'b10000, L = 5'b01000, R = 5'b00100, U = 5'b00010, D = 5'b00001;

    typedef struct {
        logic [4:0]  btn;
        logic [12:0] exp;
    } vec_t;
    vec_t vt [24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        n_vec++;
        if (outs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end
    endtask

    task automatic press(input logic [4:0] b);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        tick();
        {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
        tick();
    endtask

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h2, input logic [2:0] m1, input logic [3:0] m2);
        {H1, H2, M1, M2} = {h1, h2, m1, m2};
    endtask

    initial begin
        vt[0]  = '{C, TH};
        vt[1]  = '{U, TH | E_TH};
        vt[2]  = '{U, TH | E_TH};
        vt[3]  = '{U, TH | E_TH};
        vt[4]  = '{R, TM};
        vt[5]  = '{R, AH};
        vt[6]  = '{D, AH | E_AH | UD};
        vt[7]  = '{L, TM};
        vt[8]  = '{L, TH};
        vt[9]  = '{L, AM};
        vt[10] = '{U, AM | E_AM};
        vt[11] = '{D, AM | E_AM | UD};
        vt[12] = '{R, TH};
        vt[13] = '{R, TM};
        vt[14] = '{U | D, TM};
        vt[15] = '{U, TM | E_TM};
        vt[16] = '{L | R, TM};
        vt[17] = '{R | U, AH};
        vt[18] = '{L, TM};
        vt[19] = '{C | R, CLK_O};
        vt[20] = '{R, CLK_O};
        vt[21] = '{U, CLK_O};
        vt[22] = '{C | U, TH};
        vt[23] = '{C, CLK_O};

        tick();
        tick();
        check("reset_state", CLK_O);
        rst = 1'b1;
        tick();
        tick();
        check("idle_after_reset", CLK_O);

        for (int i = 0; i < 24; i++) begin
            press(vt[i].btn);
            check($sformatf("vec%0d", i), vt[i].exp);
            tick();
            check($sformatf("vec%0d_pulse_end", i), vt[i].exp & ~13'h03e);
        end

        // timeout: 16 idle cycles after entering T_MIN
        press(C);
        press(R);
        repeat (15) tick();
        check("tmo_15_idle", TM);
        tick();
        check("tmo_16_idle", CLK_O);

        // a step event at the last idle cycle restarts the count
        press(C);
        press(R);
        repeat (14) tick();
        btn_u = 1'b1;
        tick();
        btn_u = 1'b0;
        tick();
        check("tmo_restart_step", TM | E_TM);
        repeat (15) tick();
        check("tmo_restart_15", TM);
        tick();
        check("tmo_restart_16", CLK_O);

        // ring: 06:59 -> 07:00 with alarm armed
        alarm_en = 1'b1;
        set_time(2'd0, 4'd6, 3'd5, 4'd9);
        tick();
        tick();
        check("ring_pre", CLK_O);
        set_time(2'd0, 4'd7, 3'd0, 4'd0);
        tick();
        check("ring_on", CLK_O | RG);
        repeat (7) tick();
        check("ring_cycle8", CLK_O | RG);
        tick();
        check("ring_expired", CLK_O);
        repeat (3) tick();
        check("ring_no_retrigger", CLK_O);

        // btn_u during ring clears it without acting
        set_time(2'd0, 4'd6, 3'd5, 4'd9);
        tick();
        set_time(2'd0, 4'd7, 3'd0, 4'd0);
        tick();
        tick();
        btn_u = 1'b1;
        tick();
        btn_u = 1'b0;
        tick();
        check("ring_clear_btn_u", CLK_O);

        // btn_c during ring is consumed: no entry to adjust
        set_time(2'd0, 4'd6, 3'd5, 4'd9);
        tick();
        set_time(2'd0, 4'd7, 3'd0, 4'd0);
        tick();
        check("ring_on_again", CLK_O | RG);
        press(C);
        check("ring_clear_btn_c", CLK_O);
        tick();
        check("ring_btn_c_consumed", CLK_O);
        press(C);
        check("after_ring_enter", TH);
        press(C);
        check("after_ring_exit", CLK_O);

        // disarming clears the ring; a disarmed match never rings
        set_time(2'd0, 4'd6, 3'd5, 4'd9);
        tick();
        set_time(2'd0, 4'd7, 3'd0, 4'd0);
        tick();
        check("ring_on_en", CLK_O | RG);
        alarm_en = 1'b0;
        tick();
        check("ring_clear_en", CLK_O);
        set_time(2'd0, 4'd6, 3'd5, 4'd9);
        tick();
        set_time(2'd0, 4'd7, 3'd0, 4'd0);
        tick();
        check("ring_disarmed", CLK_O);

        // asynchronous reset in A_MIN with a step pending
        press(C);
        press(L);
        check("rst_pre_amin", AM);
        btn_u = 1'b1;
        btn_c = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_async", CLK_O);
        tick();
        tick();
        check("rst_hold", CLK_O);
        rst = 1'b1;
        repeat (4) tick();
        check("rst_release_held_btn", CLK_O);
        btn_u = 1'b0;
        btn_c = 1'b0;
        tick();
        tick();
        check("rst_after_release", CLK_O);
        press(C);
        check("rst_fresh_press", TH);
        press(C);
        check("rst_fresh_exit", CLK_O);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
